// File: rtl/tlul_pkg.sv
// tlul_pkg: TL-UL channel structures and opcode encodings shared by device blocks
package tlul_pkg;

    localparam logic [2:0] OpPutFull       = 3'd0;
    localparam logic [2:0] OpPutPartial    = 3'd1;
    localparam logic [2:0] OpGet           = 3'd4;
    localparam logic [2:0] OpAccessAck     = 3'd0;
    localparam logic [2:0] OpAccessAckData = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_sram_mem.sv
// tlul_sram_mem: TL-UL device-side SRAM with byte-masked writes, optional zeroing sweep
// and an in-order response queue bounded by a credit counter.
module tlul_sram_mem
    import tlul_pkg::*;
#(
    parameter int Depth       = 1024,
    parameter int ReadLatency = 1,
    parameter int Outstanding = 4,
    parameter int WriteEnable = 1,
    parameter int InitZero    = 0
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  tl_h2d_t tl_i,
    output tl_d2h_t tl_o,
    output logic    init_done_o
);

    localparam int AW = $clog2(Depth);
    localparam int CW = $clog2(Outstanding + 1);
    localparam int PW = (Outstanding > 1) ? $clog2(Outstanding) : 1;

    typedef enum logic {S_INIT, S_RUN} state_e;

    typedef struct packed {
        logic [2:0]  op;
        logic        err;
        logic [7:0]  src;
        logic [1:0]  size;
        logic [31:0] data;
    } rsp_t;

    state_e        r_state, w_next_state;
    logic [AW-1:0] r_sweep_ptr;
    logic [31:0]   r_mem [Depth];
    logic [31:0]   r_rdata;
    logic [CW-1:0] r_credits, r_count;
    logic          r_pv0;
    rsp_t          r_pd0;
    rsp_t          r_fifo [Outstanding];
    logic [PW-1:0] r_wptr, r_rptr;
    logic          w_a_ready, w_accept, w_is_get, w_put_ok, w_busy, w_out_v;
    logic          w_push, w_pop, w_d_valid, w_unused;
    logic [AW-1:0] w_idx;
    rsp_t          w_req, w_s0, w_out, w_push_rsp, w_head;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(Outstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i)
        r_state <= rst_i ? ((InitZero != 0) ? S_INIT : S_RUN) : w_next_state;

    always_comb
        w_next_state = (r_state == S_INIT && r_sweep_ptr == AW'(Depth - 1)) ? S_RUN : r_state;

    always_comb begin
        w_a_ready   = !rst_i && r_state == S_RUN && r_credits < CW'(Outstanding);
        init_done_o = !rst_i && r_state == S_RUN;
    end

    always_ff @(posedge clk_i)
        if (rst_i) r_sweep_ptr <= '0;
        else if (r_state == S_INIT) r_sweep_ptr <= r_sweep_ptr + 1'b1;

    always_comb begin
        w_idx     = tl_i.a_address[AW+1:2];
        w_accept  = tl_i.a_valid && w_a_ready;
        w_is_get  = tl_i.a_opcode == OpGet;
        w_put_ok  = (tl_i.a_opcode == OpPutFull || tl_i.a_opcode == OpPutPartial) && WriteEnable != 0;
        w_req     = '{op: w_is_get ? OpAccessAckData : OpAccessAck, err: !(w_is_get || w_put_ok),
                      src: tl_i.a_source, size: tl_i.a_size, data: '0};
        w_s0      = r_pd0;
        w_s0.data = (r_pd0.op == OpAccessAckData) ? r_rdata : '0;
        w_unused  = ^{tl_i.a_param, tl_i.a_address[31:AW+2], tl_i.a_address[1:0]};
    end

    always_ff @(posedge clk_i) begin
        if (r_state == S_INIT) r_mem[r_sweep_ptr] <= '0;
        else if (w_accept && w_put_ok)
            for (int b = 0; b < 4; b++)
                if (tl_i.a_mask[b]) r_mem[w_idx][8*b +: 8] <= tl_i.a_data[8*b +: 8];
        r_rdata <= r_mem[w_idx];
    end

    // Non-reads only skip the pipeline when nothing is in flight, so they never overtake a read.
    always_ff @(posedge clk_i) begin
        r_pv0 <= !rst_i && w_accept && (w_is_get || w_busy);
        r_pd0 <= w_req;
    end

    generate
        if (ReadLatency == 2) begin : g_lat2
            logic r_v1;
            rsp_t r_d1;
            always_ff @(posedge clk_i) begin
                r_v1 <= !rst_i && r_pv0;
                r_d1 <= w_s0;
            end
            always_comb begin
                w_out_v = r_v1;
                w_out   = r_d1;
                w_busy  = r_pv0 || r_v1;
            end
        end else begin : g_lat1
            always_comb begin
                w_out_v = r_pv0;
                w_out   = w_s0;
                w_busy  = r_pv0;
            end
        end
    endgenerate

    always_comb begin
        w_push     = w_out_v || (w_accept && !w_is_get && !w_busy);
        w_push_rsp = w_out_v ? w_out : w_req;
        w_d_valid  = r_count != '0;
        w_pop      = w_d_valid && tl_i.d_ready;
        w_head     = r_fifo[r_rptr];
    end

    always_ff @(posedge clk_i)
        if (rst_i) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_credits <= '0;
        end else begin
            if (w_push) r_wptr <= f_inc(r_wptr);
            if (w_pop) r_rptr <= f_inc(r_rptr);
            r_count   <= r_count + CW'(w_push) - CW'(w_pop);
            r_credits <= r_credits + CW'(w_accept) - CW'(w_pop);
        end

    always_ff @(posedge clk_i)
        if (w_push) r_fifo[r_wptr] <= w_push_rsp;

    always_comb begin
        tl_o         = '0;
        tl_o.a_ready = w_a_ready;
        tl_o.d_valid = w_d_valid;
        if (w_d_valid) begin
            tl_o.d_opcode = w_head.op;
            tl_o.d_error  = w_head.err;
            tl_o.d_source = w_head.src;
            tl_o.d_size   = w_head.size;
            tl_o.d_data   = w_head.data;
        end
    end

endmodule

// File: doc/tlul_sram_mem.md
Name: tlul_sram_mem

Overview:
- Parametrised TL-UL device-side SRAM block. Generalises the fixed 32-bit data memory to configurable depth, read latency, outstanding depth, read-only mode and optional zeroing at reset.
- Terminates one TL-UL device port directly, with no external adapter: A-channel decode, per-byte write masking, an in-order response queue and D-channel generation.
- Used for instruction memory (read-only) and data memory behind the TL-UL crossbar.

Parameters:
- Depth, 1024: number of 32-bit words; power of 2, ≥ 4. AW = clog2(Depth).
- ReadLatency, 1: SRAM read pipeline stages; legal values 1 or 2. A value of 2 adds an output register.
- Outstanding, 4: maximum accepted-but-unacknowledged requests; ≥ 1. Also sets the response FIFO depth.
- WriteEnable, 1: 0 makes the block read-only; every Put returns d_error=1 and the array is not written.
- InitZero, 0: 1 makes the block sweep all words to zero after reset before accepting requests.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; synchronous, active-high.
- tl_i  input  tlul_pkg::tl_h2d_t  TL-UL A-channel request plus d_ready.
- tl_o  output  tlul_pkg::tl_d2h_t  TL-UL D-channel response plus a_ready.
- init_done_o  output  1  high once the block is in RUN state.

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst_i. All state is in the clk_i domain.
- Reset values:
  - a_ready=0, d_valid=0, init_done_o=0.
  - d_opcode/d_data/d_error/d_source/d_size = 0.
  - Response FIFO empty, read pipeline cleared, credit counter = 0.
  - FSM goes to INIT if InitZero=1, otherwise RUN.
- Array contents are not reset, except by the INIT sweep.
- FSM:
  - INIT: writes 0 to word sweep_ptr each cycle, ptr from 0 to Depth-1. Holds a_ready=0. After word Depth-1 is written, moves to RUN. Takes exactly Depth cycles.
  - RUN: normal operation. init_done_o=1.
- Asserting rst_i at any time, including mid-sweep or with responses pending:
  - drops all pending responses;
  - restarts the FSM;
  - leaves array contents untouched when InitZero=0.
- Accept rule: a_ready = RUN && (credits < Outstanding). A request is accepted on a_valid && a_ready.
  - credits increments on accept and decrements on a D handshake (d_valid && d_ready).
  - A simultaneous accept and D handshake leaves credits unchanged.
  - Acceptance is allowed when credits == Outstanding-1 and a pop occurs in the same cycle.
- Address decode: word index = a_address[AW+1:2]. Bits above AW+1 are ignored, because the crossbar decodes them. Bits [1:0] are ignored; a_mask selects the lanes.
- Opcodes:
  - Get (4): reads the word. Response is AccessAckData (1) with d_data = the word, d_error=0.
  - PutFullData (0) and PutPartialData (1): write byte lane i iff a_mask[i]. This happens in the accept cycle. Response is AccessAck (0) with d_data=0.
  - Any other opcode: no array access. Response opcode is AccessAck (0) with d_error=1.
  - Put with WriteEnable=0: no write, AccessAck with d_error=1.
- Read timing: array data reaches the response FIFO ReadLatency cycles after accept. Writes bypass the pipeline and enter the FIFO in order behind earlier reads. Responses are strictly in acceptance order.
- Earliest d_valid:
  - ReadLatency+1 cycles after accept for a Get;
  - 1 cycle after accept for a Put, when the FIFO is otherwise empty.
- D channel: d_valid = FIFO not empty. The head entry is held stable while d_valid && !d_ready. d_source and d_size echo the request; d_param=0, d_sink=0.
- Ordering: a Get accepted the cycle after a Put to the same word returns the new data. Writes are never reordered behind reads.
- FIFO full with credits == Outstanding: a_ready=0 until a D handshake. Overflow is impossible by construction.
- Expected RTL size: about 250 lines.

Test Plan:
- Put 0xDEADBEEF to addr 0x10 with mask 0xF, then Get 0x10 → AccessAck d_error=0, then AccessAckData d_data=0xDEADBEEF, in order.
- PutPartial data 0x11223344 with mask 0b0101 over a word holding 0xAAAAAAAA, then Get → d_data=0xAA22AA44.
- Outstanding=4 with d_ready held 0: issue 6 back-to-back Gets → a_ready drops after the 4th accept. Release d_ready → all 6 responses return in order with their d_source values.
- WriteEnable=0: Put 0x1 to addr 0, then Get → Put gets d_error=1; Get returns the prior contents.
- Opcode 2 → AccessAck d_error=1 and no array change.
- InitZero=1, Depth=16: release reset → a_ready=0 for 16 cycles, init_done_o rises on cycle 16, and a Get to any address returns 0. Assert rst_i mid-sweep → the sweep restarts from 0 and pending responses are flushed.
